// File: rtl/conv_mxm_stream.sv
// conv_mxm_stream: MxM signed convolution over a column-streamed image with a reloadable kernel
// and a 4-stage round/saturate MAC pipeline.
module conv_mxm_stream #(
  parameter int BIT_LEN    = 8,
  parameter int M_LEN      = 3,
  parameter int OUT_LEN    = 8,
  parameter int OUT_SHIFT  = 7,
  parameter int OFFSET_BIN = 1
) (
  input  logic                     CLK100MHZ,
  input  logic                     i_reset,
  input  logic                     i_valid,
  input  logic                     i_selecK_I,
  input  logic [M_LEN*BIT_LEN-1:0] i_col,
  output logic [OUT_LEN-1:0]       o_data,
  output logic                     o_valid,
  output logic                     o_kernel_ready
);
  localparam int ACC_LEN = 2*BIT_LEN + $clog2(M_LEN*M_LEN);
  localparam int CW = $clog2(M_LEN+1);
  localparam logic [CW-1:0] MC = CW'(M_LEN);
  localparam logic signed [ACC_LEN:0] RND = ((ACC_LEN+1)'(1) << OUT_SHIFT) >> 1;
  localparam logic signed [ACC_LEN:0] MAXV = (ACC_LEN+1)'((1 << (OUT_LEN-1)) - 1);
  localparam logic signed [ACC_LEN:0] MINV = -MAXV - (ACC_LEN+1)'(1);
  localparam logic [OUT_LEN-1:0] FLIP = (OFFSET_BIN != 0) ? {1'b1, {(OUT_LEN-1){1'b0}}} : '0;

  logic signed [BIT_LEN-1:0] kr [M_LEN][M_LEN];
  logic signed [BIT_LEN-1:0] wr [M_LEN][M_LEN];
  logic signed [2*BIT_LEN-1:0] prod [M_LEN][M_LEN];
  logic signed [ACC_LEN-1:0] cs_c [M_LEN];
  logic signed [ACC_LEN-1:0] csum [M_LEN];
  logic signed [ACC_LEN-1:0] ts_c, tot;
  logic signed [ACC_LEN:0] rnd, sh;
  logic [OUT_LEN-1:0] sat;
  logic [CW-1:0] kcnt, icnt, icnt_nx;
  logic t0, v1, v2, v3, kbeat, ibeat;

  assign kbeat = i_valid & ~i_selecK_I;
  assign ibeat = i_valid & i_selecK_I;
  assign o_kernel_ready = (kcnt == MC);
  assign icnt_nx = (icnt == MC) ? MC : icnt + CW'(1);

  always_ff @(posedge CLK100MHZ or negedge i_reset)
    if (!i_reset) begin
      for (int j = 0; j < M_LEN; j++)
        for (int r = 0; r < M_LEN; r++) begin
          kr[j][r] <= '0;
          wr[j][r] <= '0;
        end
      kcnt <= '0;
      icnt <= '0;
      t0 <= 1'b0;
    end else begin
      t0 <= 1'b0;
      if (kbeat) begin
        for (int j = 0; j < M_LEN-1; j++) kr[j] <= kr[j+1];
        for (int r = 0; r < M_LEN; r++) kr[M_LEN-1][r] <= i_col[r*BIT_LEN +: BIT_LEN];
        kcnt <= o_kernel_ready ? CW'(1) : kcnt + CW'(1);
        icnt <= '0;
      end
      if (ibeat) begin
        for (int j = 0; j < M_LEN-1; j++) wr[j] <= wr[j+1];
        for (int r = 0; r < M_LEN; r++) wr[M_LEN-1][r] <= i_col[r*BIT_LEN +: BIT_LEN];
        icnt <= icnt_nx;
        t0 <= (icnt_nx == MC) && o_kernel_ready;
      end
    end

  always_comb begin
    ts_c = '0;
    for (int j = 0; j < M_LEN; j++) begin
      cs_c[j] = '0;
      for (int r = 0; r < M_LEN; r++) cs_c[j] = cs_c[j] + ACC_LEN'(prod[j][r]);
      ts_c = ts_c + csum[j];
    end
    rnd = {tot[ACC_LEN-1], tot} + RND;
    sh = rnd >>> OUT_SHIFT;
    sat = (sh > MAXV) ? MAXV[OUT_LEN-1:0] : (sh < MINV) ? MINV[OUT_LEN-1:0] : sh[OUT_LEN-1:0];
  end

  // A kernel beat kills every in-flight token so no result mixes old and new kernels.
  always_ff @(posedge CLK100MHZ or negedge i_reset)
    if (!i_reset) begin
      for (int j = 0; j < M_LEN; j++) begin
        csum[j] <= '0;
        for (int r = 0; r < M_LEN; r++) prod[j][r] <= '0;
      end
      tot <= '0;
      {v1, v2, v3, o_valid} <= '0;
      o_data <= '0;
    end else begin
      for (int j = 0; j < M_LEN; j++) begin
        csum[j] <= cs_c[j];
        for (int r = 0; r < M_LEN; r++) prod[j][r] <= kr[j][r] * wr[j][r];
      end
      tot <= ts_c;
      v1 <= t0 & ~kbeat;
      v2 <= v1 & ~kbeat;
      v3 <= v2 & ~kbeat;
      o_valid <= v3 & ~kbeat;
      if (v3 & ~kbeat) o_data <= sat ^ FLIP;
    end
endmodule

// File: tb/tb_conv_mxm_stream.sv
// tb_conv_mxm_stream: directed checks of the 3x3 convolver, offset-binary and two's complement builds
// driven side by side, with a small arithmetic reference model scoring streamed results.
module tb_conv_mxm_stream;
  logic clk, i_reset, i_valid, i_selecK_I;
  logic [23:0] i_col;
  logic [7:0] o_data, o_data0;
  logic o_valid, o_valid0, o_kernel_ready, o_kernel_ready0;

  typedef struct {int due; logic [7:0] d; logic [7:0] d0;} exp_t;
  exp_t q[$];
  int km [3][3], wm [3][3];
  int mk, mi, cyc, nv, n0, checks, errors;

  conv_mxm_stream dut (.CLK100MHZ(clk), .i_reset(i_reset), .i_valid(i_valid), .i_selecK_I(i_selecK_I),
    .i_col(i_col), .o_data(o_data), .o_valid(o_valid), .o_kernel_ready(o_kernel_ready));
  conv_mxm_stream #(.OFFSET_BIN(0)) dut0 (.CLK100MHZ(clk), .i_reset(i_reset), .i_valid(i_valid),
    .i_selecK_I(i_selecK_I), .i_col(i_col), .o_data(o_data0), .o_valid(o_valid0),
    .o_kernel_ready(o_kernel_ready0));

  initial begin
    clk = 0;
    forever #5 clk = ~clk;
  end

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  function automatic logic [7:0] ref_out(input bit ob);
    int acc = 0;
    for (int j = 0; j < 3; j++)
      for (int r = 0; r < 3; r++) acc += km[j][r] * wm[j][r];
    acc = (acc + 64) >>> 7;
    if (acc > 127) acc = 127;
    else if (acc < -128) acc = -128;
    return ob ? (8'(acc) ^ 8'h80) : 8'(acc);
  endfunction

  function automatic logic [23:0] imgcol(input int b);
    return {8'(b*41 - 90), 8'(3 - b*17), 8'(b*29 + 5)};
  endfunction

  task automatic tick();
    exp_t e;
    @(posedge clk);
    #1;
    cyc++;
    if (o_valid || o_valid0) begin
      nv++;
      if (q.size() == 0) chk("unexpected_valid", 64'(o_valid | o_valid0), 64'(0));
      else begin
        e = q.pop_front();
        chk("result", {o_valid, o_valid0, cyc, o_data, o_data0}, {2'b11, e.due, e.d, e.d0});
      end
    end
  endtask

  task automatic idle(input int n);
    i_valid = 0;
    repeat (n) begin
      i_selecK_I = 1'($urandom_range(0, 1));
      i_col = 24'($urandom);
      tick();
    end
  endtask

  task automatic kbeat(input logic [23:0] c);
    i_valid = 1;
    i_selecK_I = 0;
    i_col = c;
    q.delete();
    tick();
    for (int j = 0; j < 2; j++) km[j] = km[j+1];
    for (int r = 0; r < 3; r++) km[2][r] = int'($signed(c[r*8 +: 8]));
    mk = (mk == 3) ? 1 : mk + 1;
    mi = 0;
    i_valid = 0;
  endtask

  task automatic ibeat(input logic [23:0] c);
    i_valid = 1;
    i_selecK_I = 1;
    i_col = c;
    tick();
    for (int j = 0; j < 2; j++) wm[j] = wm[j+1];
    for (int r = 0; r < 3; r++) wm[2][r] = int'($signed(c[r*8 +: 8]));
    mi = (mi == 3) ? 3 : mi + 1;
    if (mi == 3 && mk == 3) q.push_back('{cyc + 4, ref_out(1), ref_out(0)});
    i_valid = 0;
  endtask

  task automatic model_reset();
    q.delete();
    mk = 0;
    mi = 0;
    for (int j = 0; j < 3; j++)
      for (int r = 0; r < 3; r++) begin
        km[j][r] = 0;
        wm[j][r] = 0;
      end
  endtask

  task automatic kvaried();
    kbeat(24'hFEFDFC);
    kbeat(24'h0100FF);
    kbeat(24'h040302);
  endtask

  initial begin
    checks = 0; errors = 0; cyc = 0; nv = 0;
    model_reset();
    i_reset = 1; i_valid = 0; i_selecK_I = 0; i_col = 0;
    #2 i_reset = 0;
    tick();
    tick();
    chk("rst_valid", o_valid, 0);
    chk("rst_data", {o_data, o_data0}, 16'h0);
    chk("rst_kready", o_kernel_ready, 0);
    @(negedge clk) i_reset = 1;

    kbeat(24'h0);
    kbeat(24'h004000);
    chk("kready_2of3", o_kernel_ready, 0);
    kbeat(24'h0);
    chk("kready_3of3", o_kernel_ready, 1);
    repeat (3) ibeat(24'h646464);
    idle(4);
    chk("centre_valid", o_valid, 1);
    chk("centre_data", {o_data, o_data0}, 16'hB232);
    idle(1);
    chk("hold_data", {o_valid, o_data}, {1'b0, 8'hB2});

    repeat (3) kbeat(24'h7F7F7F);
    repeat (3) ibeat(24'h7F7F7F);
    idle(4);
    chk("sat_pos", {o_valid, o_data, o_data0}, {1'b1, 8'hFF, 8'h7F});
    repeat (3) kbeat(24'h808080);
    repeat (3) ibeat(24'h7F7F7F);
    idle(4);
    chk("sat_neg", {o_valid, o_data, o_data0}, {1'b1, 8'h00, 8'h80});

    kvaried();
    n0 = nv;
    ibeat(imgcol(1));
    ibeat(imgcol(2));
    idle(4);
    chk("fill_none", 64'(nv - n0), 64'(0));
    for (int b = 3; b <= 10; b++) ibeat(imgcol(b));
    idle(5);
    chk("fill_count", 64'(nv - n0), 64'(8));

    kvaried();
    n0 = nv;
    for (int b = 0; b < 10; b++) begin
      ibeat(imgcol(b + 20));
      idle($urandom_range(0, 3));
    end
    idle(5);
    chk("stall_count", 64'(nv - n0), 64'(8));
    chk("stall_drain", 64'(q.size()), 64'(0));

    kvaried();
    n0 = nv;
    for (int b = 0; b < 5; b++) ibeat(imgcol(b + 40));
    kbeat(24'h02FF01);
    chk("reload_kready1", o_kernel_ready, 0);
    kbeat(24'h7F0180);
    chk("reload_kready2", o_kernel_ready, 0);
    kbeat(24'hFD0405);
    chk("reload_kready3", o_kernel_ready, 1);
    idle(6);
    chk("reload_flushed", 64'(nv - n0), 64'(0));
    ibeat(imgcol(50));
    ibeat(imgcol(51));
    idle(5);
    chk("reload_refill", 64'(nv - n0), 64'(0));
    ibeat(imgcol(52));
    idle(5);
    chk("reload_first", 64'(nv - n0), 64'(1));

    ibeat(imgcol(60));
    idle(4);
    chk("pre_reset_valid", o_valid, 1);
    #3 i_reset = 0;
    #1;
    chk("async_valid", {o_valid, o_valid0}, 2'b00);
    chk("async_data", {o_data, o_data0}, 16'h0);
    chk("async_kready", o_kernel_ready, 0);
    model_reset();
    @(negedge clk) i_reset = 1;
    n0 = nv;
    for (int b = 0; b < 3; b++) ibeat(imgcol(b + 70));
    idle(6);
    chk("post_reset_none", 64'(nv - n0), 64'(0));
    kvaried();
    for (int b = 0; b < 3; b++) ibeat(imgcol(b + 80));
    idle(5);
    chk("post_reset_one", 64'(nv - n0), 64'(1));
    chk("final_drain", 64'(q.size()), 64'(0));

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end
endmodule
